hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 5-stage MIPS core.
- Keeps a shadow copy of destination-register state for the EX, MEM and WB stages.
- From that state it generates PC and IF/ID hold, ID/EX bubble insertion, branch/jump flushes, and EX-stage operand forwarding selects.
- Parametrised in register-address width, load-use stall length and flush depth, so the same block serves the current core and later ones with longer memory latency or earlier branch resolution.

Parameters:
- REG_ADDR_W, 5: register address width; address 0 is hardwired zero and is never a hazard source.
- LOAD_STALL, 1: stall cycles inserted on a load-use hazard; legal range 1..3.
- FLUSH_DEPTH, 3: number of younger stages flushed on a redirect; 2 = resolve in EX, 3 = resolve in MEM.
- CNT_W, 16: width of the performance counters (optional feature only).

Ports:
- clk, input, 1: clock.
- arst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: global run; when low the block holds all state.
- id_rs, input, REG_ADDR_W: rs of the instruction in ID.
- id_rt, input, REG_ADDR_W: rt of the instruction in ID.
- id_uses_rs, input, 1: ID instruction reads rs.
- id_uses_rt, input, 1: ID instruction reads rt.
- id_waddr, input, REG_ADDR_W: resolved destination of the ID instruction.
- id_reg_write, input, 1: ID instruction writes the register file.
- id_mem_read, input, 1: ID instruction is a load.
- redirect, input, 1: taken branch or jump resolved at stage FLUSH_DEPTH.
- pc_en, output, 1: PC update enable.
- if_id_en, output, 1: IF/ID register enable.
- if_id_flush, output, 1: zero the IF/ID register.
- id_ex_bubble, output, 1: force ID/EX control signals to zero.
- ex_mem_flush, output, 1: zero EX/MEM control signals; only meaningful when FLUSH_DEPTH = 3.
- fwd_a, output, 2: EX operand A source; 00 = register file, 01 = EX/MEM alu_out, 10 = MEM/WB write data.
- fwd_b, output, 2: EX operand B source; same encoding as fwd_a.

Behaviour:
- Reset / idle values: all shadow valid bits 0, stall counter 0, FSM in RUN; fwd_a = fwd_b = 00, all flush and bubble outputs 0.
- enable low: pc_en = if_id_en = 0, flush and bubble outputs 0, no state change.
- Shadow pipe:
  - Per stage (EX, MEM, WB): valid, waddr, reg_write, mem_read, plus rs/rt for EX.
  - Advances on each enabled clock.
  - EX is loaded from the ID inputs, or with valid = 0 when a bubble or flush is issued that cycle.
- Load-use detect (combinational): ex.valid & ex.mem_read & ex.waddr != 0 & ((id_uses_rs & id_rs == ex.waddr) | (id_uses_rt & id_rt == ex.waddr)).
- FSM states RUN and STALL:
  - RUN: on load-use detect, drive pc_en = if_id_en = 0 and id_ex_bubble = 1. If LOAD_STALL > 1, load the counter with LOAD_STALL - 1 and go to STALL.
  - STALL: hold pc_en = if_id_en = 0 and id_ex_bubble = 1, decrement the counter, return to RUN when it reaches 0.
  - Total stall = exactly LOAD_STALL cycles.
- Redirect:
  - Has priority over any stall.
  - In the same cycle: if_id_flush = 1, id_ex_bubble = 1, ex_mem_flush = (FLUSH_DEPTH == 3), pc_en = 1.
  - Shadow EX valid is cleared, plus MEM valid if FLUSH_DEPTH = 3.
  - FSM is forced to RUN and the counter to 0.
- Forwarding (combinational from shadow EX rs/rt versus MEM and WB):
  - fwd = 01 if mem.valid & mem.reg_write & mem.waddr != 0 & mem.waddr == src.
  - Else fwd = 10 if the same condition holds for the WB stage.
  - Else fwd = 00.
  - MEM has priority over WB when both match.
- Address 0: never stalls and never forwards.
- Reset mid-stall: the FSM returns to RUN immediately and asynchronously.

Optional Feature:
- Macro: HAZARD_CTRL_PERF_EN.
- When defined, adds three outputs: stall_cnt, flush_cnt and fwd_cnt, each CNT_W wide.
  - stall_cnt counts cycles with id_ex_bubble caused by a stall.
  - flush_cnt counts redirect cycles.
  - fwd_cnt counts EX cycles where fwd_a or fwd_b is nonzero.
  - All three saturate at all-ones, reset to 0 and count only while enable is high.
- When not defined, the ports and logic are absent.

Decomposition:
- Shared package holds:
  - fwd_sel_t encoding constants: FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10.
  - Stall FSM state constants.
- One sub-module, hazard_fwd_sel: the per-operand forwarding comparator, instantiated twice (operand A and operand B).

Test Plan:
- Load-use: lw r2 in EX, ID reads rs = 2 with LOAD_STALL = 1 -> one cycle of pc_en = 0, if_id_en = 0, id_ex_bubble = 1; then fwd_a = 10 on the dependent instruction's EX cycle.
- LOAD_STALL = 3, same hazard -> exactly 3 stall cycles, then RUN; PC advances on the 4th cycle.
- Double match: add r3 in MEM and add r3 in WB, EX rs = 3 -> fwd_a = 01 (MEM wins); with rt = 0 and reg_write set -> fwd_b = 00.
- Redirect during STALL (FLUSH_DEPTH = 3) -> same cycle if_id_flush = id_ex_bubble = ex_mem_flush = 1 and pc_en = 1; next cycle fwd_a = fwd_b = 00 and FSM in RUN.
- enable = 0 mid-stall for 5 cycles -> counter and state frozen; the stall resumes and completes its remaining cycles after enable returns to 1.
- arst_n pulsed low during STALL -> all outputs return to their reset values asynchronously; with HAZARD_CTRL_PERF_EN defined, all counters read 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_pkg
// Brief    : Shared types and constants for the hazard/forwarding controller:
//            forwarding-select encoding and stall FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    // EX operand source select
    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF    = 2'b00;  // register file read data
    localparam fwd_sel_t FWD_EXMEM = 2'b01;  // EX/MEM alu_out
    localparam fwd_sel_t FWD_MEMWB = 2'b10;  // MEM/WB write data

    // Load-use stall FSM
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } stall_state_t;

endpackage : hazard_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_sel
// Brief    : Per-operand forwarding comparator. Compares one EX source
//            register against the MEM and WB destinations; the younger MEM
//            result wins over WB. Register 0 never forwards.
// Ports    : src_valid/src            - EX stage valid and source register
//            mem_valid/_reg_write/_waddr - MEM stage destination state
//            wb_valid/_reg_write/_waddr  - WB stage destination state
//            sel                      - forwarding select (fwd_sel_t)
// Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_sel
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  src_valid,
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_waddr,
    input  logic                  wb_valid,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_waddr,
    output fwd_sel_t              sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    // A bubble in EX has no real operands, so it never requests forwarding.
    assign w_mem_hit = src_valid & mem_valid & mem_reg_write &
                       (mem_waddr != '0) & (mem_waddr == src);
    assign w_wb_hit  = src_valid & wb_valid & wb_reg_write &
                       (wb_waddr != '0) & (wb_waddr == src);

    always_comb begin
        sel = FWD_RF;
        if (w_mem_hit) begin
            sel = FWD_EXMEM;
        end else if (w_wb_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule : hazard_fwd_sel
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline hazard and forwarding controller for the 5-stage MIPS
//            core. Shadows EX/MEM/WB destination state and produces PC and
//            IF/ID hold, ID/EX bubble, redirect flushes and EX forwarding.
// Ports    : clk, arst_n (async active-low), enable (global run)
//            id_*            - decoded ID-stage instruction fields
//            redirect        - taken branch/jump resolved at FLUSH_DEPTH
//            pc_en, if_id_en - front-end update enables
//            if_id_flush, id_ex_bubble, ex_mem_flush - squash controls
//            fwd_a, fwd_b    - EX operand source selects
// Options  : HAZARD_CTRL_PERF_EN adds stall_cnt, flush_cnt, fwd_cnt
//            (CNT_W-bit saturating event counters).
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int LOAD_STALL  = 1,   // 1..3
    parameter int FLUSH_DEPTH = 3,   // 2 = EX resolve, 3 = MEM resolve
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  enable,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_waddr,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  redirect,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      fwd_cnt
`endif
);

    localparam int       c_SCNT_W     = 2;
    localparam logic     c_FLUSH_MEM  = (FLUSH_DEPTH == 3);
    localparam logic     c_MULTI_STALL = (LOAD_STALL > 1);
    localparam logic [c_SCNT_W-1:0] c_STALL_RELOAD = c_SCNT_W'(LOAD_STALL - 1);

    // ------------------------------------------------------------------
    // Shadow pipe. The load flag is only kept for EX: it is the only
    // stage a load-use hazard is detected against.
    // ------------------------------------------------------------------
    logic                  r_ex_valid;
    logic [REG_ADDR_W-1:0] r_ex_waddr;
    logic                  r_ex_reg_write;
    logic                  r_ex_mem_read;
    logic [REG_ADDR_W-1:0] r_ex_rs;
    logic [REG_ADDR_W-1:0] r_ex_rt;

    logic                  r_mem_valid;
    logic [REG_ADDR_W-1:0] r_mem_waddr;
    logic                  r_mem_reg_write;

    logic                  r_wb_valid;
    logic [REG_ADDR_W-1:0] r_wb_waddr;
    logic                  r_wb_reg_write;

    stall_state_t          r_state;
    stall_state_t          w_next_state;
    logic [c_SCNT_W-1:0]   r_scnt;
    logic [c_SCNT_W-1:0]   w_next_scnt;

    logic                  w_load_use;
    logic                  w_stall;

    assign w_load_use = r_ex_valid & r_ex_mem_read & (r_ex_waddr != '0) &
                        ((id_uses_rs & (id_rs == r_ex_waddr)) |
                         (id_uses_rt & (id_rt == r_ex_waddr)));

    // ------------------------------------------------------------------
    // Stall FSM: next state and pipeline control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_scnt  = r_scnt;
        w_stall      = 1'b0;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_flush = 1'b0;

        if (!enable) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
        end else if (redirect) begin
            // Redirect squashes the stalled instruction anyway, so it
            // overrides the stall and the front end fetches the target.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = c_FLUSH_MEM;
            w_next_state = ST_RUN;
            w_next_scnt  = '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_load_use) begin
                        w_stall = 1'b1;
                        if (c_MULTI_STALL) begin
                            w_next_state = ST_STALL;
                            w_next_scnt  = c_STALL_RELOAD;
                        end
                    end
                end
                ST_STALL: begin
                    w_stall     = 1'b1;
                    w_next_scnt = r_scnt - 1'b1;
                    if (r_scnt == c_SCNT_W'(1)) begin
                        w_next_state = ST_RUN;
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                    w_next_scnt  = '0;
                end
            endcase
        end

        if (w_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_RUN;
            r_scnt  <= '0;
        end else if (enable) begin
            r_state <= w_next_state;
            r_scnt  <= w_next_scnt;
        end
    end

    // ------------------------------------------------------------------
    // Shadow pipe advance
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_ex_valid      <= 1'b0;
            r_ex_waddr      <= '0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_rs         <= '0;
            r_ex_rt         <= '0;
            r_mem_valid     <= 1'b0;
            r_mem_waddr     <= '0;
            r_mem_reg_write <= 1'b0;
            r_wb_valid      <= 1'b0;
            r_wb_waddr      <= '0;
            r_wb_reg_write  <= 1'b0;
        end else if (enable) begin
            r_ex_valid      <= ~id_ex_bubble;
            r_ex_waddr      <= id_waddr;
            r_ex_reg_write  <= id_reg_write;
            r_ex_mem_read   <= id_mem_read;
            r_ex_rs         <= id_rs;
            r_ex_rt         <= id_rt;
            r_mem_valid     <= r_ex_valid & ~ex_mem_flush;
            r_mem_waddr     <= r_ex_waddr;
            r_mem_reg_write <= r_ex_reg_write;
            r_wb_valid      <= r_mem_valid;
            r_wb_waddr      <= r_mem_waddr;
            r_wb_reg_write  <= r_mem_reg_write;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding selects
    // ------------------------------------------------------------------
    hazard_fwd_sel #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_a (
        .src_valid     (r_ex_valid),
        .src           (r_ex_rs),
        .mem_valid     (r_mem_valid),
        .mem_reg_write (r_mem_reg_write),
        .mem_waddr     (r_mem_waddr),
        .wb_valid      (r_wb_valid),
        .wb_reg_write  (r_wb_reg_write),
        .wb_waddr      (r_wb_waddr),
        .sel           (fwd_a)
    );

    hazard_fwd_sel #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_b (
        .src_valid     (r_ex_valid),
        .src           (r_ex_rt),
        .mem_valid     (r_mem_valid),
        .mem_reg_write (r_mem_reg_write),
        .mem_waddr     (r_mem_waddr),
        .wb_valid      (r_wb_valid),
        .wb_reg_write  (r_wb_reg_write),
        .wb_waddr      (r_wb_waddr),
        .sel           (fwd_b)
    );

`ifdef HAZARD_CTRL_PERF_EN
    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_fwd_cnt;
    logic             w_fwd_any;

    assign w_fwd_any = (fwd_a != FWD_RF) | (fwd_b != FWD_RF);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else if (enable) begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
            if (w_fwd_any && (r_fwd_cnt != '1)) begin
                r_fwd_cnt <= r_fwd_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed self-checking bench for hazard_ctrl. Three instances
//            share one stimulus: A (LOAD_STALL=1, FLUSH_DEPTH=3),
//            B (LOAD_STALL=3, FLUSH_DEPTH=3), C (LOAD_STALL=1, FLUSH_DEPTH=2).
//            HAZARD_CTRL_PERF_EN enables the counter checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic       clk;
    logic       arst_n;
    logic       enable;
    logic [4:0] id_rs, id_rt, id_waddr;
    logic       id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
    logic       redirect;

    logic       a_pc_en, a_if_id_en, a_if_id_flush, a_bubble, a_ex_mem_flush;
    logic [1:0] a_fwd_a, a_fwd_b;
    logic       b_pc_en, b_if_id_en, b_if_id_flush, b_bubble, b_ex_mem_flush;
    logic [1:0] b_fwd_a, b_fwd_b;
    logic       c_pc_en, c_if_id_en, c_if_id_flush, c_bubble, c_ex_mem_flush;
    logic [1:0] c_fwd_a, c_fwd_b;
`ifdef HAZARD_CTRL_PERF_EN
    logic [15:0] a_stall_cnt, a_flush_cnt, a_fwd_cnt;
    logic [15:0] b_stall_cnt, b_flush_cnt, b_fwd_cnt;
    logic [15:0] c_stall_cnt, c_flush_cnt, c_fwd_cnt;
`endif

    int n_run;
    int n_fail;

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(1), .FLUSH_DEPTH(3), .CNT_W(16)) u_dut_a (
        .clk(clk), .arst_n(arst_n), .enable(enable),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_waddr(id_waddr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .redirect(redirect),
        .pc_en(a_pc_en), .if_id_en(a_if_id_en), .if_id_flush(a_if_id_flush),
        .id_ex_bubble(a_bubble), .ex_mem_flush(a_ex_mem_flush),
        .fwd_a(a_fwd_a), .fwd_b(a_fwd_b)
`ifdef HAZARD_CTRL_PERF_EN
        , .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt), .fwd_cnt(a_fwd_cnt)
`endif
    );

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(3), .FLUSH_DEPTH(3), .CNT_W(16)) u_dut_b (
        .clk(clk), .arst_n(arst_n), .enable(enable),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_waddr(id_waddr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .redirect(redirect),
        .pc_en(b_pc_en), .if_id_en(b_if_id_en), .if_id_flush(b_if_id_flush),
        .id_ex_bubble(b_bubble), .ex_mem_flush(b_ex_mem_flush),
        .fwd_a(b_fwd_a), .fwd_b(b_fwd_b)
`ifdef HAZARD_CTRL_PERF_EN
        , .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt), .fwd_cnt(b_fwd_cnt)
`endif
    );

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(1), .FLUSH_DEPTH(2), .CNT_W(16)) u_dut_c (
        .clk(clk), .arst_n(arst_n), .enable(enable),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_waddr(id_waddr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .redirect(redirect),
        .pc_en(c_pc_en), .if_id_en(c_if_id_en), .if_id_flush(c_if_id_flush),
        .id_ex_bubble(c_bubble), .ex_mem_flush(c_ex_mem_flush),
        .fwd_a(c_fwd_a), .fwd_b(c_fwd_b)
`ifdef HAZARD_CTRL_PERF_EN
        , .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt), .fwd_cnt(c_fwd_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt,
                          input logic [4:0] wa, input logic rw, input logic mr);
        id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_waddr = wa; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic set_nop();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        arst_n   = 1'b0;
        enable   = 1'b1;
        redirect = 1'b0;
        set_nop();
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        #1;
        n_run++; if (a_pc_en !== 1'b1)        begin n_fail++; $display("FAIL rst_pc_en got=%b exp=1", a_pc_en); end
        n_run++; if (a_if_id_en !== 1'b1)     begin n_fail++; $display("FAIL rst_if_id_en got=%b exp=1", a_if_id_en); end
        n_run++; if (a_if_id_flush !== 1'b0)  begin n_fail++; $display("FAIL rst_if_id_flush got=%b exp=0", a_if_id_flush); end
        n_run++; if (a_bubble !== 1'b0)       begin n_fail++; $display("FAIL rst_bubble got=%b exp=0", a_bubble); end
        n_run++; if (a_ex_mem_flush !== 1'b0) begin n_fail++; $display("FAIL rst_ex_mem_flush got=%b exp=0", a_ex_mem_flush); end
        n_run++; if (a_fwd_a !== 2'b00)       begin n_fail++; $display("FAIL rst_fwd_a got=%b exp=00", a_fwd_a); end
        n_run++; if (a_fwd_b !== 2'b00)       begin n_fail++; $display("FAIL rst_fwd_b got=%b exp=00", a_fwd_b); end
    endtask

    // lw r2 ; add r4,r2,r5 with LOAD_STALL=1 (instance A)
    task automatic test_load_use();
        do_reset();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
        #1;
        n_run++; if (a_pc_en !== 1'b1) begin n_fail++; $display("FAIL lu_pre_pc_en got=%b exp=1", a_pc_en); end
        tick();
        set_id(5'd2, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        #1;
        n_run++; if (a_pc_en !== 1'b0)    begin n_fail++; $display("FAIL lu_pc_en got=%b exp=0", a_pc_en); end
        n_run++; if (a_if_id_en !== 1'b0) begin n_fail++; $display("FAIL lu_if_id_en got=%b exp=0", a_if_id_en); end
        n_run++; if (a_bubble !== 1'b1)   begin n_fail++; $display("FAIL lu_bubble got=%b exp=1", a_bubble); end
        tick();
        n_run++; if (a_pc_en !== 1'b1)    begin n_fail++; $display("FAIL lu_release_pc_en got=%b exp=1", a_pc_en); end
        n_run++; if (a_bubble !== 1'b0)   begin n_fail++; $display("FAIL lu_release_bubble got=%b exp=0", a_bubble); end
        tick();
        set_nop();
        #1;
        n_run++; if (a_fwd_a !== 2'b10) begin n_fail++; $display("FAIL lu_fwd_a got=%b exp=10", a_fwd_a); end
        n_run++; if (a_fwd_b !== 2'b00) begin n_fail++; $display("FAIL lu_fwd_b got=%b exp=00", a_fwd_b); end
    endtask

    // Same hazard with LOAD_STALL=3 (instance B)
    task automatic test_load_stall3();
        do_reset();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
        tick();
        set_id(5'd2, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            #1;
            n_run++; if (b_pc_en !== 1'b0)  begin n_fail++; $display("FAIL ls3_cyc%0d_pc_en got=%b exp=0", i, b_pc_en); end
            n_run++; if (b_bubble !== 1'b1) begin n_fail++; $display("FAIL ls3_cyc%0d_bubble got=%b exp=1", i, b_bubble); end
            tick();
        end
        #1;
        n_run++; if (b_pc_en !== 1'b1)    begin n_fail++; $display("FAIL ls3_cyc4_pc_en got=%b exp=1", b_pc_en); end
        n_run++; if (b_if_id_en !== 1'b1) begin n_fail++; $display("FAIL ls3_cyc4_if_id_en got=%b exp=1", b_if_id_en); end
        n_run++; if (b_bubble !== 1'b0)   begin n_fail++; $display("FAIL ls3_cyc4_bubble got=%b exp=0", b_bubble); end
        tick();
        set_nop();
        #1;
        // The load has retired by the time the consumer reaches EX.
        n_run++; if (b_fwd_a !== 2'b00) begin n_fail++; $display("FAIL ls3_fwd_a got=%b exp=00", b_fwd_a); end
`ifdef HAZARD_CTRL_PERF_EN
        n_run++; if (b_stall_cnt !== 16'd3) begin n_fail++; $display("FAIL ls3_stall_cnt got=%0d exp=3", b_stall_cnt); end
`endif
    endtask

    // add r3 ; add r3 ; x(rs=3,rt=0) ; y(rs=6,rt=3)
    task automatic test_double_match();
        do_reset();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        tick();
        set_id(5'd3, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        tick();
        set_id(5'd6, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        #1;
        n_run++; if (a_fwd_a !== 2'b01) begin n_fail++; $display("FAIL dm_fwd_a got=%b exp=01", a_fwd_a); end
        n_run++; if (a_fwd_b !== 2'b00) begin n_fail++; $display("FAIL dm_fwd_b got=%b exp=00", a_fwd_b); end
        tick();
        set_nop();
        #1;
        n_run++; if (a_fwd_a !== 2'b01) begin n_fail++; $display("FAIL dm2_fwd_a got=%b exp=01", a_fwd_a); end
        n_run++; if (a_fwd_b !== 2'b10) begin n_fail++; $display("FAIL dm2_fwd_b got=%b exp=10", a_fwd_b); end
    endtask

    // Writers and loads of r0 never stall and never forward
    task automatic test_zero_reg();
        do_reset();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        #1;
        n_run++; if (a_pc_en !== 1'b1)  begin n_fail++; $display("FAIL z_pc_en got=%b exp=1", a_pc_en); end
        n_run++; if (a_bubble !== 1'b0) begin n_fail++; $display("FAIL z_bubble got=%b exp=0", a_bubble); end
        tick();
        set_nop();
        #1;
        n_run++; if (a_fwd_a !== 2'b00) begin n_fail++; $display("FAIL z_fwd_a got=%b exp=00", a_fwd_a); end
        n_run++; if (a_fwd_b !== 2'b00) begin n_fail++; $display("FAIL z_fwd_b got=%b exp=00", a_fwd_b); end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
        tick();
        set_id(5'd2, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        tick();
        // B is now in STALL with the dependent add held in ID
        redirect = 1'b1;
        #1;
        n_run++; if (b_if_id_flush !== 1'b1)  begin n_fail++; $display("FAIL rd_if_id_flush got=%b exp=1", b_if_id_flush); end
        n_run++; if (b_bubble !== 1'b1)       begin n_fail++; $display("FAIL rd_bubble got=%b exp=1", b_bubble); end
        n_run++; if (b_ex_mem_flush !== 1'b1) begin n_fail++; $display("FAIL rd_ex_mem_flush got=%b exp=1", b_ex_mem_flush); end
        n_run++; if (b_pc_en !== 1'b1)        begin n_fail++; $display("FAIL rd_pc_en got=%b exp=1", b_pc_en); end
        n_run++; if (c_ex_mem_flush !== 1'b0) begin n_fail++; $display("FAIL rd_d2_ex_mem_flush got=%b exp=0", c_ex_mem_flush); end
        n_run++; if (c_if_id_flush !== 1'b1)  begin n_fail++; $display("FAIL rd_d2_if_id_flush got=%b exp=1", c_if_id_flush); end
        tick();
        redirect = 1'b0;
        set_nop();
        #1;
        n_run++; if (b_fwd_a !== 2'b00) begin n_fail++; $display("FAIL rd_next_fwd_a got=%b exp=00", b_fwd_a); end
        n_run++; if (b_fwd_b !== 2'b00) begin n_fail++; $display("FAIL rd_next_fwd_b got=%b exp=00", b_fwd_b); end
        n_run++; if (b_pc_en !== 1'b1)  begin n_fail++; $display("FAIL rd_next_pc_en got=%b exp=1", b_pc_en); end
        n_run++; if (b_bubble !== 1'b0) begin n_fail++; $display("FAIL rd_next_bubble got=%b exp=0", b_bubble); end
        // Writer of r9 in EX at redirect: depth 3 kills it, depth 2 keeps it
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
        tick();
        redirect = 1'b1;
        set_id(5'd9, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        tick();
        redirect = 1'b0;
        tick();
        set_nop();
        #1;
        n_run++; if (b_fwd_a !== 2'b00) begin n_fail++; $display("FAIL rd_d3_killed_fwd_a got=%b exp=00", b_fwd_a); end
        n_run++; if (c_fwd_a !== 2'b10) begin n_fail++; $display("FAIL rd_d2_kept_fwd_a got=%b exp=10", c_fwd_a); end
`ifdef HAZARD_CTRL_PERF_EN
        n_run++; if (b_flush_cnt !== 16'd2) begin n_fail++; $display("FAIL rd_flush_cnt got=%0d exp=2", b_flush_cnt); end
`endif
    endtask

    task automatic test_enable_freeze();
        do_reset();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
        tick();
        set_id(5'd2, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        tick();
        n_run++; if (b_bubble !== 1'b1) begin n_fail++; $display("FAIL en_stall2_bubble got=%b exp=1", b_bubble); end
        enable = 1'b0;
        #1;
        n_run++; if (b_pc_en !== 1'b0)    begin n_fail++; $display("FAIL en_off_pc_en got=%b exp=0", b_pc_en); end
        n_run++; if (b_if_id_en !== 1'b0) begin n_fail++; $display("FAIL en_off_if_id_en got=%b exp=0", b_if_id_en); end
        n_run++; if (b_bubble !== 1'b0)   begin n_fail++; $display("FAIL en_off_bubble got=%b exp=0", b_bubble); end
        repeat (5) tick();
        n_run++; if (b_bubble !== 1'b0)   begin n_fail++; $display("FAIL en_off5_bubble got=%b exp=0", b_bubble); end
        enable = 1'b1;
        #1;
        n_run++; if (b_bubble !== 1'b1) begin n_fail++; $display("FAIL en_resume2_bubble got=%b exp=1", b_bubble); end
        n_run++; if (b_pc_en !== 1'b0)  begin n_fail++; $display("FAIL en_resume2_pc_en got=%b exp=0", b_pc_en); end
        tick();
        n_run++; if (b_bubble !== 1'b1) begin n_fail++; $display("FAIL en_resume3_bubble got=%b exp=1", b_bubble); end
        tick();
        n_run++; if (b_pc_en !== 1'b1)  begin n_fail++; $display("FAIL en_done_pc_en got=%b exp=1", b_pc_en); end
        n_run++; if (b_bubble !== 1'b0) begin n_fail++; $display("FAIL en_done_bubble got=%b exp=0", b_bubble); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
        tick();
        set_id(5'd2, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        tick();
        #1;
        n_run++; if (b_bubble !== 1'b1) begin n_fail++; $display("FAIL ar_pre_bubble got=%b exp=1", b_bubble); end
        arst_n = 1'b0;
        #1;
        n_run++; if (b_bubble !== 1'b0)   begin n_fail++; $display("FAIL ar_bubble got=%b exp=0", b_bubble); end
        n_run++; if (b_pc_en !== 1'b1)    begin n_fail++; $display("FAIL ar_pc_en got=%b exp=1", b_pc_en); end
        n_run++; if (b_if_id_en !== 1'b1) begin n_fail++; $display("FAIL ar_if_id_en got=%b exp=1", b_if_id_en); end
        n_run++; if (b_fwd_a !== 2'b00)   begin n_fail++; $display("FAIL ar_fwd_a got=%b exp=00", b_fwd_a); end
`ifdef HAZARD_CTRL_PERF_EN
        n_run++; if (b_stall_cnt !== 16'd0) begin n_fail++; $display("FAIL ar_stall_cnt got=%0d exp=0", b_stall_cnt); end
        n_run++; if (b_flush_cnt !== 16'd0) begin n_fail++; $display("FAIL ar_flush_cnt got=%0d exp=0", b_flush_cnt); end
        n_run++; if (b_fwd_cnt !== 16'd0)   begin n_fail++; $display("FAIL ar_fwd_cnt got=%0d exp=0", b_fwd_cnt); end
`endif
        #1 arst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_run    = 0;
        n_fail   = 0;
        arst_n   = 1'b0;
        enable   = 1'b0;
        redirect = 1'b0;
        set_nop();
        test_reset();
        test_load_use();
        test_load_stall3();
        test_double_match();
        test_zero_reg();
        test_redirect_stall();
        test_enable_freeze();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
